// File: rtl/btb_predictor_pkg.sv
// Shared types for the fetch-stage branch predictor: 2-bit direction
// counter type, its reset/allocate values and the update-stage record.
package btb_predictor_pkg;

    localparam int BP_XLEN = 32;

    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t BP_CTR_RESET = 2'b01;
    localparam bp_ctr_t BP_CTR_ALLOC = 2'b10;
    localparam bp_ctr_t BP_CTR_MAX   = 2'b11;
    localparam bp_ctr_t BP_CTR_MIN   = 2'b00;

    // Branch resolution captured from EX, held for one cycle before the write
    typedef struct packed {
        logic [BP_XLEN-1:0] pc;
        logic               taken;
        logic [BP_XLEN-1:0] target;
    } btb_update_t;

endpackage

// File: rtl/btb_predictor_if.sv
// Predictor bus: fetch lookup and EX training signals.
// master = fetch/EX side, slave = btb_predictor.
interface btb_predictor_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] fetch_pc;
    logic             pred_hit;
    logic             pred_taken;
    logic [WIDTH-1:0] pred_target;
    logic             upd_valid;
    logic [WIDTH-1:0] upd_pc;
    logic             upd_taken;
    logic [WIDTH-1:0] upd_target;
    logic             upd_busy;

    modport master (
        output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
        input  pred_hit, pred_taken, pred_target, upd_busy
    );

    modport slave (
        input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
        output pred_hit, pred_taken, pred_target, upd_busy
    );
endinterface

// File: rtl/btb_predictor_bp_sat_counter.sv
// 2-bit saturating direction counter, combinational next value:
// increments toward 11 on taken, decrements toward 00 on not-taken.
module bp_sat_counter
    import btb_predictor_pkg::*;
(
    input  bp_ctr_t i_ctr,
    input  logic    i_inc,
    output bp_ctr_t o_ctr
);

    // Saturating step in the direction of the resolved outcome
    always_comb begin
        o_ctr = i_ctr;
        if (i_inc) begin
            if (i_ctr != BP_CTR_MAX) begin
                o_ctr = i_ctr + 2'b01;
            end else begin
                o_ctr = i_ctr;
            end
        end else begin
            if (i_ctr != BP_CTR_MIN) begin
                o_ctr = i_ctr - 2'b01;
            end else begin
                o_ctr = i_ctr;
            end
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters. Lookup is combinational
// from fetch_pc; training goes through a one-cycle registered update stage.
// Optional macro BTB_BYPASS_EN: lookup forwards the stage-2 write data when
// the write index equals the lookup index (new entry visible in the write
// cycle). Without it, a new entry becomes visible the cycle after the write.
// WIDTH must equal BP_XLEN because the update record is a fixed-width struct.
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int S_INDEX = 3,
    parameter int WIDTH   = 32
) (
    input  logic           clk,
    input  logic           rst,
    btb_predictor_if.slave bp
);

    localparam int N_ENT = 1 << S_INDEX;
    localparam int TAG_W = WIDTH - S_INDEX - 2;
    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    // Entry storage
    logic             r_valid  [N_ENT];
    logic [TAG_W-1:0] r_tag    [N_ENT];
    logic [WIDTH-1:0] r_target [N_ENT];
    bp_ctr_t          r_ctr    [N_ENT];

    // Update stage register
    logic        r_upd_vld;
    btb_update_t r_upd;

    // Stage-2 read/modify signals
    logic [S_INDEX-1:0] w_upd_idx;
    logic [TAG_W-1:0]   w_upd_tag;
    logic               w_upd_hit;
    bp_ctr_t            w_ctr_next;
    logic               w_we;
    logic               w_wr_valid;
    logic [TAG_W-1:0]   w_wr_tag;
    logic [WIDTH-1:0]   w_wr_target;
    bp_ctr_t            w_wr_ctr;

    // Lookup signals
    logic [S_INDEX-1:0] w_fetch_idx;
    logic [TAG_W-1:0]   w_fetch_tag;
    logic               w_lk_valid;
    logic [TAG_W-1:0]   w_lk_tag;
    logic [WIDTH-1:0]   w_lk_target;
    bp_ctr_t            w_lk_ctr;
    logic               w_lk_hit;
    logic               w_lk_taken;

    // Byte-offset bits never take part in index or tag
    logic w_unused_bits;
    assign w_unused_bits = ^{bp.fetch_pc[1:0], r_upd.pc[1:0]};

    assign w_upd_idx   = r_upd.pc[S_INDEX+1:2];
    assign w_upd_tag   = r_upd.pc[WIDTH-1:S_INDEX+2];
    assign w_upd_hit   = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_fetch_idx = bp.fetch_pc[S_INDEX+1:2];
    assign w_fetch_tag = bp.fetch_pc[WIDTH-1:S_INDEX+2];

    bp_sat_counter u_ctr (
        .i_ctr (r_ctr[w_upd_idx]),
        .i_inc (r_upd.taken),
        .o_ctr (w_ctr_next)
    );

    // Stage 1: capture EX resolution; cleared by reset so no write survives it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_upd_vld <= 1'b0;
            r_upd     <= '0;
        end else begin
            r_upd_vld <= bp.upd_valid;
            if (bp.upd_valid) begin
                r_upd <= '{pc: bp.upd_pc, taken: bp.upd_taken, target: bp.upd_target};
            end
        end
    end

    // Stage 2: decide train-in-place, allocate, or no write
    always_comb begin
        w_we        = 1'b0;
        w_wr_valid  = r_valid[w_upd_idx];
        w_wr_tag    = w_upd_tag;
        w_wr_target = r_target[w_upd_idx];
        w_wr_ctr    = r_ctr[w_upd_idx];
        if (r_upd_vld) begin
            if (w_upd_hit) begin
                w_we       = 1'b1;
                w_wr_valid = 1'b1;
                w_wr_ctr   = w_ctr_next;
                if (r_upd.taken) begin
                    w_wr_target = r_upd.target;
                end else begin
                    w_wr_target = r_target[w_upd_idx];
                end
            end else if (r_upd.taken) begin
                w_we        = 1'b1;
                w_wr_valid  = 1'b1;
                w_wr_target = r_upd.target;
                w_wr_ctr    = BP_CTR_ALLOC;
            end else begin
                w_we = 1'b0;
            end
        end else begin
            w_we = 1'b0;
        end
    end

    // Entry array write; the following update reads this value directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ENT; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= BP_CTR_RESET;
            end
        end else if (w_we) begin
            r_valid[w_upd_idx]  <= w_wr_valid;
            r_tag[w_upd_idx]    <= w_wr_tag;
            r_target[w_upd_idx] <= w_wr_target;
            r_ctr[w_upd_idx]    <= w_wr_ctr;
        end
    end

    // Lookup entry select, optionally forwarding the in-flight write
    always_comb begin
        w_lk_valid  = r_valid[w_fetch_idx];
        w_lk_tag    = r_tag[w_fetch_idx];
        w_lk_target = r_target[w_fetch_idx];
        w_lk_ctr    = r_ctr[w_fetch_idx];
`ifdef BTB_BYPASS_EN
        if (w_we && (w_upd_idx == w_fetch_idx)) begin
            w_lk_valid  = w_wr_valid;
            w_lk_tag    = w_wr_tag;
            w_lk_target = w_wr_target;
            w_lk_ctr    = w_wr_ctr;
        end else begin
            w_lk_valid  = r_valid[w_fetch_idx];
        end
`else
        w_lk_valid = r_valid[w_fetch_idx];
`endif
    end

    assign w_lk_hit   = w_lk_valid && (w_lk_tag == w_fetch_tag);
    assign w_lk_taken = w_lk_hit && w_lk_ctr[1];

    assign bp.pred_hit    = w_lk_hit;
    assign bp.pred_taken  = w_lk_taken;
    assign bp.pred_target = w_lk_taken ? w_lk_target : (bp.fetch_pc + PC_STEP);
    assign bp.upd_busy    = r_upd_vld;

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed scenarios followed by
// random lookups/updates, all compared to a table-level reference model.
// Honors BTB_BYPASS_EN the same way as the design.
module tb_btb_predictor;

    logic clk;
    logic rst;

    btb_predictor_if #(.WIDTH(32)) bif ();

    btb_predictor #(.S_INDEX(3), .WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 8 entries plus one pending (captured, not yet written) update
    bit          m_v   [8];
    logic [26:0] m_tag [8];
    logic [31:0] m_tgt [8];
    int          m_ctr [8];
    bit          p_v;
    logic [31:0] p_pc;
    bit          p_tk;
    logic [31:0] p_tgt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
        end
        p_v = 1'b0;
    endtask

    // Training rule applied to one entry
    task automatic train(inout bit v, inout logic [26:0] t, inout logic [31:0] g, inout int c,
                         input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
        if (v && t == pc[31:5]) begin
            if (tk) begin
                c = (c >= 3) ? 3 : c + 1;
                g = tgt;
            end else begin
                c = (c <= 0) ? 0 : c - 1;
            end
        end else if (tk) begin
            v = 1'b1; t = pc[31:5]; g = tgt; c = 2;
        end
    endtask

    task automatic check_lookup(input logic [31:0] fpc);
        int          idx;
        bit          v;
        logic [26:0] t;
        logic [31:0] g;
        int          c;
        bit          eh;
        bit          et;
        logic [31:0] eg;
        idx = int'(fpc[4:2]);
        v = m_v[idx]; t = m_tag[idx]; g = m_tgt[idx]; c = m_ctr[idx];
`ifdef BTB_BYPASS_EN
        if (p_v && int'(p_pc[4:2]) == idx) train(v, t, g, c, p_pc, p_tk, p_tgt);
`endif
        eh = v && (t == fpc[31:5]);
        et = eh && (c >= 2);
        eg = et ? g : fpc + 32'd4;
        check("pred_hit",    {31'd0, bif.pred_hit},   {31'd0, eh});
        check("pred_taken",  {31'd0, bif.pred_taken}, {31'd0, et});
        check("pred_target", bif.pred_target, eg);
        check("upd_busy",    {31'd0, bif.upd_busy},   {31'd0, p_v});
    endtask

    // One clock: drive at negedge, check model, then advance model at posedge
    task automatic step(input bit uv, input logic [31:0] upc, input bit ut,
                        input logic [31:0] utg, input logic [31:0] fpc);
        @(negedge clk);
        bif.upd_valid  = uv;
        bif.upd_pc     = upc;
        bif.upd_taken  = ut;
        bif.upd_target = utg;
        bif.fetch_pc   = fpc;
        #1;
        check_lookup(fpc);
        @(posedge clk);
        if (p_v) begin
            int          idx;
            bit          v;
            logic [26:0] t;
            logic [31:0] g;
            int          c;
            idx = int'(p_pc[4:2]);
            v = m_v[idx]; t = m_tag[idx]; g = m_tgt[idx]; c = m_ctr[idx];
            train(v, t, g, c, p_pc, p_tk, p_tgt);
            m_v[idx] = v; m_tag[idx] = t; m_tgt[idx] = g; m_ctr[idx] = c;
        end
        p_v = uv; p_pc = upc; p_tk = ut; p_tgt = utg;
    endtask

    // Idle-cycle lookup also compared against literal expectations
    task automatic look(input string tag, input logic [31:0] fpc,
                        input bit eh, input bit et, input logic [31:0] eg);
        @(negedge clk);
        bif.upd_valid = 1'b0;
        bif.fetch_pc  = fpc;
        #1;
        check({tag, "_hit"},    {31'd0, bif.pred_hit},   {31'd0, eh});
        check({tag, "_taken"},  {31'd0, bif.pred_taken}, {31'd0, et});
        check({tag, "_target"}, bif.pred_target, eg);
        step(1'b0, 32'd0, 1'b0, 32'd0, fpc);
    endtask

    task automatic idle(input logic [31:0] fpc);
        step(1'b0, 32'd0, 1'b0, 32'd0, fpc);
    endtask

    function automatic logic [31:0] mk_pc(input int tag, input int idx);
        logic [26:0] t;
        logic [2:0]  i;
        t = 27'(tag);
        i = 3'(idx);
        return {t, i, 2'b00};
    endfunction

    initial begin
        rst = 1'b1;
        bif.fetch_pc = 32'h100; bif.upd_valid = 1'b0;
        bif.upd_pc = '0; bif.upd_taken = 1'b0; bif.upd_target = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Post-reset lookup
        look("t1", 32'h100, 1'b0, 1'b0, 32'h104);

        // Allocate taken branch, visible two cycles later with ctr 10
        step(1'b1, 32'h100, 1'b1, 32'h200, 32'h100);
        idle(32'h100);
        look("t2", 32'h100, 1'b1, 1'b1, 32'h200);

        // Not-taken twice: 10 -> 01 -> 00, then a third keeps 00
        step(1'b1, 32'h100, 1'b0, 32'h0, 32'h100);
        step(1'b1, 32'h100, 1'b0, 32'h0, 32'h100);
        idle(32'h100);
        look("t3a", 32'h100, 1'b1, 1'b0, 32'h104);
        step(1'b1, 32'h100, 1'b0, 32'h0, 32'h100);
        idle(32'h100);
        look("t3b", 32'h100, 1'b1, 1'b0, 32'h104);
        // One taken from 00 reaches only 01: still predicted not-taken
        step(1'b1, 32'h100, 1'b1, 32'h240, 32'h100);
        idle(32'h100);
        look("t3c", 32'h100, 1'b1, 1'b0, 32'h104);

        // Aliasing replaces the entry
        step(1'b1, 32'h120, 1'b1, 32'h300, 32'h120);
        idle(32'h120);
        look("t4a", 32'h100, 1'b0, 1'b0, 32'h104);
        look("t4b", 32'h120, 1'b1, 1'b1, 32'h300);

        // Back-to-back training on one index: 10 -> 11 saturates, last target wins
        step(1'b1, 32'h100, 1'b1, 32'h200, 32'h100);
        step(1'b1, 32'h100, 1'b1, 32'h204, 32'h100);
        step(1'b1, 32'h100, 1'b1, 32'h208, 32'h100);
        step(1'b1, 32'h100, 1'b1, 32'h20C, 32'h100);
        idle(32'h100);
        look("t5a", 32'h100, 1'b1, 1'b1, 32'h20C);
        // 11 -> 10 -> 01 back-to-back: only correct if neither update is lost
        step(1'b1, 32'h100, 1'b0, 32'h0, 32'h100);
        step(1'b1, 32'h100, 1'b0, 32'h0, 32'h100);
        idle(32'h100);
        look("t5b", 32'h100, 1'b1, 1'b0, 32'h104);

        // Fall-through wraps at the top of the address space
        look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

        // Reset while an update is pending; upd_valid during reset is ignored
        step(1'b1, 32'h100, 1'b1, 32'h500, 32'h100);
        @(negedge clk);
        check("pre_rst_busy", {31'd0, bif.upd_busy}, 32'd1);
        rst = 1'b1;
        bif.upd_valid = 1'b1; bif.upd_pc = 32'h108; bif.upd_taken = 1'b1; bif.upd_target = 32'h600;
        #1;
        check("rst_busy", {31'd0, bif.upd_busy}, 32'd0);
        check("rst_hit",  {31'd0, bif.pred_hit}, 32'd0);
        check("rst_tgt",  bif.pred_target, 32'h104);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bif.upd_valid = 1'b0;
        for (int i = 0; i < 8; i++) look("t6", mk_pc(i == 0 ? 8 : (i == 2 ? 8 : 0), i),
                                         1'b0, 1'b0, mk_pc(i == 0 ? 8 : (i == 2 ? 8 : 0), i) + 32'd4);

        // Randomized traffic over a few tags per index to force hits and aliasing
        for (int n = 0; n < 600; n++) begin
            logic [31:0] upc;
            logic [31:0] fpc;
            upc = mk_pc(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
            if ($urandom_range(0, 15) == 0) fpc = 32'hFFFF_FFFC;
            else if ($urandom_range(0, 2) == 0) fpc = upc;
            else fpc = mk_pc(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
            step($urandom_range(0, 3) != 0, upc, $urandom_range(0, 2) != 0,
                 $urandom & 32'hFFFF_FFFC, fpc);
        end
        idle(32'h100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
